mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Microsequencer that drives the 16-bit Datapath control word to compute an unsigned
//  product P = A*B by repeated addition. Register use: R0=A, R1=B (loop counter), R2=P.
//  Sits between the debounced front-panel inputs and Datapath. It replaces the manual
//  mode/start control-word selection and reads Datapath Z/C flags to control the loop.
// PARAMETERS
//  WIDTH  8       datapath data width (Data_in, constant, operands)
//  RA     3'd0    register address holding A
//  RB     3'd1    register address holding B / loop counter
//  RP     3'd2    register address holding product
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  reset         in   1      synchronous active-high reset
//  start         in   1      one-cycle pulse (already debounced); begins a multiply
//  a_in          in   WIDTH  operand A, captured on accepted start
//  b_in          in   WIDTH  operand B, captured on accepted start
//  z_in          in   1      Datapath Z flag (combinational from current control word)
//  c_in          in   1      Datapath C flag (combinational from current control word)
//  control_word  out  16     {DA[15:13],AA[12:10],BA[9:7],MB[6],FS[5:2],MD[1],RW[0]}
//  data_out      out  WIDTH  drives Datapath Data_in
//  constant_out  out  WIDTH  drives Datapath constant_in; always 0
//  busy          out  1      high in every state except IDLE
//  done          out  1      high for exactly the DONE cycle
//  ovf           out  1      sticky: product exceeded WIDTH bits in last run
// BEHAVIOUR
//  - Moore FSM. control_word/data_out decode from current state only; Datapath writes
//    at the edge that ends the state. Unlisted fields = 0.
//  - Reset: state=IDLE, control_word=16'h0000 (RW=0, no write), data_out=0, busy=0,
//    done=0, ovf=0, captured operands=0. Reset mid-run aborts immediately; R0..R2 keep
//    partial values.
//  - IDLE:   cw=0. start=1 -> capture a_in,b_in, clear ovf, go LOAD_A. Else stay.
//  - LOAD_A: DA=RA, MD=1, RW=1, data_out=A -> LOAD_B.
//  - LOAD_B: DA=RB, MD=1, RW=1, data_out=B -> CLR.
//  - CLR:    DA=RP, MB=1, FS=1100 (MOVB const 0), MD=0, RW=1 -> TEST.
//  - TEST:   AA=RB, FS=0000 (MOVA), RW=0. z_in=1 -> DONE, else -> ADD.
//  - ADD:    DA=RP, AA=RP, BA=RA, FS=0010 (A+B), RW=1. c_in=1 sets ovf -> DEC.
//  - DEC:    DA=RB, AA=RB, FS=0110 (A-1), RW=1 -> TEST.
//  - DONE:   AA=RP, FS=0000, RW=0 (Datapath Data_out shows P), done=1 -> IDLE.
//  - data_out=0 outside LOAD_A/LOAD_B.
//  - Latency: start sampled at edge 0 -> done high in the cycle after edge 4+3*B.
//    B=0 skips the loop (P=0). Max run B=255 -> 769 cycles.
//  - start while busy: ignored, no re-capture. start in the DONE cycle: ignored.
//  - Arithmetic: P is modulo 2^WIDTH. ovf is the OR of c_in over all ADD cycles.
//    ovf holds until the next accepted start or reset.
//  - a_in/b_in changes after capture have no effect on the run in progress.
// TESTING
//  1 A=5,B=3, start @edge0 -> done @edge13, R2=15, ovf=0, busy high edges1..13.
//  2 A=0,B=7 -> 7 loop passes, R2=0, done @edge25, ovf=0.
//  3 A=7,B=0 -> TEST exits at once, done @edge4, R2=0, no ADD/DEC cycle seen.
//  4 A=16,B=16 -> R2=0 (256 mod 256), ovf=1. Then A=2,B=2 -> R2=4, ovf=0.
//  5 A=9,B=9, reset at edge8 -> next cycle cw=0, busy=0, done never pulses.
//    Then A=3,B=4 -> R2=12.
//  6 A=4,B=5 with start re-pulsed at edges 3 and 10 -> ignored, R2=20, done once @edge19.

Source files
------------

// File: rtl/mult_sequencer.sv
// Microsequencer that computes P = A*B on the Datapath by repeated addition.
// R0 holds A, R1 holds B and counts down, R2 accumulates the product.
module mult_sequencer #(
    parameter int         WIDTH = 8,
    parameter logic [2:0] RA    = 3'd0,
    parameter logic [2:0] RB    = 3'd1,
    parameter logic [2:0] RP    = 3'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             z_in,
    input  logic             c_in,
    output logic [15:0]      control_word,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] constant_out,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD_A | write A from data_out into RA
    // LOAD_B | write B from data_out into RB
    // CLR    | RP <= constant 0
    // TEST   | pass RB through the ALU so Z reports B == 0
    // ADD    | RP <= RP + RA, carry makes ovf sticky
    // DEC    | RB <= RB - 1
    // DONE   | RP on the Datapath output bus, done pulse
    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, CLR, TEST, ADD, DEC, DONE
    } state_t;

    localparam logic [3:0] FS_MOVA = 4'b0000;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_DEC  = 4'b0110;
    localparam logic [3:0] FS_MOVB = 4'b1100;

    state_t           state;
    logic [WIDTH-1:0] b_reg;

    function automatic logic [15:0] make_cw(
        input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
        input logic mb, input logic [3:0] fs, input logic md, input logic rw
    );
        return {da, aa, ba, mb, fs, md, rw};
    endfunction

    function automatic logic [15:0] cw_for(input state_t s);
        case (s)
            LOAD_A:  return make_cw(RA, 3'd0, 3'd0, 1'b0, FS_MOVA, 1'b1, 1'b1);
            LOAD_B:  return make_cw(RB, 3'd0, 3'd0, 1'b0, FS_MOVA, 1'b1, 1'b1);
            CLR:     return make_cw(RP, 3'd0, 3'd0, 1'b1, FS_MOVB, 1'b0, 1'b1);
            TEST:    return make_cw(3'd0, RB, 3'd0, 1'b0, FS_MOVA, 1'b0, 1'b0);
            ADD:     return make_cw(RP, RP, RA, 1'b0, FS_ADD, 1'b0, 1'b1);
            DEC:     return make_cw(RB, RB, 3'd0, 1'b0, FS_DEC, 1'b0, 1'b1);
            DONE:    return make_cw(3'd0, RP, 3'd0, 1'b0, FS_MOVA, 1'b0, 1'b0);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic go, input logic z);
        case (s)
            IDLE:    return go ? LOAD_A : IDLE;
            LOAD_A:  return LOAD_B;
            LOAD_B:  return CLR;
            CLR:     return TEST;
            TEST:    return z ? DONE : ADD;
            ADD:     return DEC;
            DEC:     return TEST;
            default: return IDLE;
        endcase
    endfunction

    assign constant_out = '0;

    // Outputs are registered from the next state, so they always match the
    // state register exactly as a Moore decode would.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            control_word <= 16'h0000;
            data_out     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            b_reg        <= '0;
        end else begin
            state        <= next_state(state, start, z_in);
            control_word <= cw_for(next_state(state, start, z_in));
            busy         <= (next_state(state, start, z_in) != IDLE);
            done         <= (next_state(state, start, z_in) == DONE);
            data_out     <= '0;

            if (state == IDLE && start) begin
                // A is captured directly into data_out for the LOAD_A cycle
                b_reg    <= b_in;
                data_out <= a_in;
                ovf      <= 1'b0;
            end else if (state == LOAD_A) begin
                data_out <= b_reg;
            end

            if (state == ADD && c_in)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer with a small behavioural Datapath (register file + ALU).
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a_in, b_in;
    logic        z_in, c_in;
    logic [15:0] control_word;
    logic [7:0]  data_out, constant_out;
    logic        busy, done, ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .z_in(z_in), .c_in(c_in), .control_word(control_word), .data_out(data_out),
        .constant_out(constant_out), .busy(busy), .done(done), .ovf(ovf)
    );

    // Datapath model
    logic [7:0] rf [0:7];
    logic [2:0] da, aa, ba;
    logic       mb, md, rw;
    logic [3:0] fs;
    logic [7:0] abus, bbus;
    logic [8:0] fr;

    assign {da, aa, ba, mb, fs, md, rw} = control_word;

    always_comb begin
        abus = rf[aa];
        bbus = mb ? constant_out : rf[ba];
        case (fs)
            4'b0000: fr = {1'b0, abus};
            4'b0010: fr = {1'b0, abus} + {1'b0, bbus};
            4'b0110: fr = {1'b0, abus} + 9'h0FF;
            4'b1100: fr = {1'b0, bbus};
            default: fr = 9'h000;
        endcase
        z_in = (fr[7:0] == 8'h00);
        c_in = fr[8];
    end

    always @(posedge clk)
        if (rw) rf[da] <= md ? data_out : fr[7:0];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int a; int b; int p; int ov; int edge_n; int rp1; int rp2;
    } vec_t;

    // rp1/rp2: edge at which an extra start pulse is sampled (-1 = none)
    task automatic run_mult(input vec_t v);
        int first_done = -1;
        int ndone = 0;
        int busy_err = 0;
        int loop_cw = 0;
        @(negedge clk);
        a_in  = v.a[7:0];
        b_in  = v.b[7:0];
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = (v.rp1 == 1) || (v.rp2 == 1);
        chk($sformatf("load_a_data a=%0d", v.a), data_out, v.a);
        chk("load_a_cw", control_word, 16'h0003);
        a_in = ~v.a[7:0];
        b_in = ~v.b[7:0];
        for (int k = 1; k <= v.edge_n + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k + 1 == v.rp1) || (k + 1 == v.rp2);
            if (k == 1) begin
                chk("load_b_data", data_out, v.b);
                chk("load_b_cw", control_word, 16'h2003);
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            if (busy != (k <= v.edge_n)) busy_err++;
            if (control_word == 16'h4809 || control_word == 16'h2419) loop_cw++;
        end
        start = 1'b0;
        chk($sformatf("done_edge a=%0d b=%0d", v.a, v.b), first_done, v.edge_n);
        chk("done_count", ndone, 1);
        chk("busy_window", busy_err, 0);
        chk("loop_cycles", loop_cw, 2 * v.b);
        chk($sformatf("product a=%0d b=%0d", v.a, v.b), rf[2], v.p);
        chk("ovf", ovf, v.ov);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{5,   3,   15, 0, 13,  -1, -1};
        vecs[1] = '{0,   7,   0,  0, 25,  -1, -1};
        vecs[2] = '{7,   0,   0,  0, 4,   -1, -1};
        vecs[3] = '{16,  16,  0,  1, 52,  -1, -1};
        vecs[4] = '{2,   2,   4,  0, 10,  -1, -1};
        vecs[5] = '{4,   5,   20, 0, 19,  3,  10};
        vecs[6] = '{1,   1,   1,  0, 7,   8,  -1};
        vecs[7] = '{255, 255, 1,  1, 769, -1, -1};
        vecs[8] = '{200, 1,   200,0, 7,   -1, -1};

        reset = 1'b1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cw", control_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", data_out, 0);
        chk("const_zero", constant_out, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_mult(vecs[i]);

        // Reset mid-run: A=9, B=9, reset sampled at edge 8
        begin
            int ndone = 0;
            int busy_seen = 0;
            @(negedge clk);
            a_in  = 8'd9;
            b_in  = 8'd9;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done) ndone++;
            end
            chk("pre_abort_busy", busy, 1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("abort_cw", control_word, 0);
            chk("abort_busy", busy, 0);
            chk("abort_data", data_out, 0);
            reset = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done) ndone++;
                if (busy) busy_seen++;
            end
            chk("abort_no_done", ndone, 0);
            chk("abort_stays_idle", busy_seen, 0);
        end
        run_mult('{3, 4, 12, 0, 16, -1, -1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
